// File: rtl/chan_merge_pkg.sv
// Shared constants and the round-robin arbitration helper for the channel merge buffer.
package chan_merge_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_DEPTH    = 4;
    localparam int MAX_CHANNELS = 16;
    localparam int GRANT_W      = 4;

    // Returns the first requester after 'last' (wrapping modulo n); returns 'last'
    // unchanged when nothing requests, so callers must qualify with |req.
    function automatic logic [GRANT_W-1:0] rr_next_grant(
        input logic [GRANT_W-1:0]      last,
        input logic [MAX_CHANNELS-1:0] req,
        input int unsigned             n
    );
        logic [GRANT_W-1:0] grant;
        logic               found;
        int unsigned        idx;
        grant = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_CHANNELS; i++) begin
            idx = (32'(last) + i) % n;
            if (!found && (i <= n) && req[idx[GRANT_W-1:0]]) begin
                grant = idx[GRANT_W-1:0];
                found = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/chan_fifo.sv
// Single-channel FIFO: WIDTH x DEPTH storage, registered fill count, combinational head read.
module chan_fifo
    import chan_merge_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/chan_merge_buffer.sv
// Merges CHANNELS independent FIFO streams into one registered output using
// masked round-robin arbitration.
module chan_merge_buffer
    import chan_merge_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DEPTH    = DEF_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [CHANNELS-1:0]               in_valid,
    input  logic [WIDTH-1:0]                  in_data   [CHANNELS],
    output logic [CHANNELS-1:0]               in_ready,
    input  logic [CHANNELS-1:0]               cfg_mask,
    output logic                              out_valid,
    output logic [WIDTH-1:0]                  out_data,
    output logic [$clog2(CHANNELS)-1:0]       out_chan,
    input  logic                              out_ready,
    output logic [$clog2(DEPTH+1)-1:0]        occupancy [CHANNELS]
);

    localparam int CW = $clog2(CHANNELS);
    localparam int OW = $clog2(DEPTH + 1);

    logic [CHANNELS-1:0] full_vec;
    logic [CHANNELS-1:0] empty_vec;
    logic [CHANNELS-1:0] pop_vec;
    logic [CHANNELS-1:0] eligible;
    logic [WIDTH-1:0]    fifo_rdata [CHANNELS];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CW-1:0]    out_chan_q, out_chan_d;
    logic [CW-1:0]    last_grant_q, last_grant_d;
    logic [CW-1:0]    grant;
    logic             loadable;

    // Handshake: a word moves on any edge where valid and ready are both high;
    // in_ready depends only on registered counts, never on a same-cycle pop.
    assign in_ready = ~full_vec;
    assign eligible = cfg_mask & ~empty_vec;
    assign loadable = !out_valid_q || out_ready;
    assign grant    = CW'(rr_next_grant(GRANT_W'(last_grant_q),
                                        MAX_CHANNELS'(eligible),
                                        CHANNELS));

    for (genvar c = 0; c < CHANNELS; c++) begin : g_fifo
        chan_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .CNT_W (OW)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push_i  (in_valid[c]),
            .pop_i   (pop_vec[c]),
            .wdata_i (in_data[c]),
            .rdata_o (fifo_rdata[c]),
            .count_o (occupancy[c]),
            .full_o  (full_vec[c]),
            .empty_o (empty_vec[c])
        );
    end

    always_comb begin
        pop_vec      = '0;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_chan_d   = out_chan_q;
        last_grant_d = last_grant_q;
        if (loadable) begin
            if (|eligible) begin
                pop_vec[grant] = 1'b1;
                out_valid_d    = 1'b1;
                out_data_d     = fifo_rdata[grant];
                out_chan_d     = grant;
                last_grant_d   = grant;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // last_grant resets to the top channel so the first search begins at channel 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_chan_q   <= '0;
            last_grant_q <= CW'(CHANNELS - 1);
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_chan_q   <= out_chan_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule
